muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 24 ++
 rtl/muldiv_ctrl_step.sv | 34 +++
 rtl/muldiv_ctrl.sv | 139 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared op codes, FSM state encoding and helpers for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_ctrl_pkg;

  // One-hot op request codes carried on mul_control.
  localparam logic [3:0] mult_mc  = 4'b0001;
  localparam logic [3:0] multu_mc = 4'b0010;
  localparam logic [3:0] div_mc   = 4'b0100;
  localparam logic [3:0] divu_mc  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_t;

  // True only for exactly one bit set; zero and multi-bit codes are not requests.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_step.sv
// muldiv_step: one iteration of shift-add multiply or restoring divide (purely combinational).
// Latency: 0 cycles. Ports: is_div selects divide; acc = partial product/remainder,
// mq = multiplier/quotient register, opnd = multiplicand/divisor; *_nxt = next values. Backpressure: none.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: conditionally add, then shift {carry, acc, mq} right by one.
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    // Divide: shift the next dividend bit into the remainder, trial-subtract.
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    acc_nxt = sum[WIDTH:1];
    mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    if (is_div) begin
      // Non-negative difference keeps the subtraction and sets the quotient bit.
      acc_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      mq_nxt  = {mq[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MIPS-style mult/multu/div/divu unit with HI/LO registers and mthi/mtlo.
// Latency: WIDTH+2 busy cycles after acceptance; HI/LO updated WIDTH+3 cycles after the request.
// Backpressure: while busy, requests/mthi/mtlo/mfhi/mflo are ignored and stall_req asks the pipe to hold.
// Ports: clk, rst (sync, active-high); mul_control one-hot op; src_a/src_b operands;
// hi_we/lo_we/wdata for mthi/mtlo; hilo_rd for mfhi/mflo; hi_out/lo_out, busy, stall_req outputs.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       mul_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall_req
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_raw, b_raw;      // operands as accepted, kept for divide-by-zero
  logic [WIDTH-1:0] opnd_q, acc_q, mq_q;
  logic             neg_q, neg_r;      // sign of product/quotient, sign of remainder
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_nxt, mq_nxt;

  logic             accept, is_div, is_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign accept    = (state == IDLE) && is_onehot4(mul_control);
  assign is_div    = op_q[2] | op_q[3];
  assign is_signed = op_q[0] | op_q[2];
  assign a_neg     = is_signed & a_raw[WIDTH-1];
  assign b_neg     = is_signed & b_raw[WIDTH-1];
  assign stall_req = busy & ((mul_control != 4'd0) | hi_we | lo_we | hilo_rd);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc_q),
    .mq      (mq_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  // Sign correction applied in FIX; magnitudes were computed unsigned.
  always_comb begin
    prod     = {acc_q, mq_q};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_raw == '0) begin
        // Divide by zero returns a fixed pattern regardless of signedness.
        res_lo = '1;
        res_hi = a_raw;
      end else begin
        res_lo = neg_q ? -mq_q : mq_q;
        res_hi = neg_r ? -acc_q : acc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_out <= '0;
      lo_out <= '0;
      busy   <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      a_raw  <= '0;
      b_raw  <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      mq_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (hi_we) hi_out <= wdata;
          if (lo_we) lo_out <= wdata;
          if (accept) begin
            op_q  <= mul_control;
            a_raw <= src_a;
            b_raw <= src_b;
          end
        end
        PREP: begin
          mq_q   <= a_neg ? -a_raw : a_raw;
          opnd_q <= b_neg ? -b_raw : b_raw;
          acc_q  <= '0;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          cnt_q  <= '0;
        end
        CALC: begin
          acc_q <= acc_nxt;
          mq_q  <= mq_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          hi_out <= res_hi;
          lo_out <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int W = 32;
  localparam int EXP_BUSY = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   mul_control;
  logic [W-1:0] src_a, src_b, wdata;
  logic         hi_we, lo_we, hilo_rd;
  logic [W-1:0] hi_out, lo_out;
  logic         busy, stall_req;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mul_control(mul_control), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hilo_rd(hilo_rd),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall_req(stall_req)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain 64-bit arithmetic following the architectural rules.
  task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      mult_mc:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      multu_mc: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      div_mc, divu_mc: begin
        if (b == 0) begin
          lo = '1;
          hi = a;
        end else if (op == div_mc) begin
          q = sa / sb; r = sa % sb;
          p = q; lo = p[31:0];
          p = r; hi = p[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one op in the current IDLE cycle and wait (bounded) for completion.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int nbusy, output logic [W-1:0] hi, output logic [W-1:0] lo);
    mul_control = op;
    src_a = a;
    src_b = b;
    step();
    mul_control = 4'd0;
    src_a = $urandom;
    src_b = $urandom;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      step();
    end
    hi = hi_out;
    lo = lo_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mul_control = 4'd0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; hilo_rd = 1'b0;
    repeat (3) step();
    vectors++;
    if (busy !== 1'b0 || hi_out !== '0 || lo_out !== '0 || stall_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: busy=%b hi=%h lo=%h stall=%b, expected 0/0/0/0", busy, hi_out, lo_out, stall_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]   ops[6] = '{multu_mc, mult_mc, div_mc, divu_mc, div_mc, divu_mc};
    logic [W-1:0] as[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd9};
    logic [W-1:0] bs[6]  = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd2};
    logic [W-1:0] ehi[6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd0, 32'd1};
    logic [W-1:0] elo[6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd4};
    int nb;
    logic [W-1:0] h, l;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], bs[i], nb, h, l);
      vectors++;
      if (nb !== EXP_BUSY || h !== ehi[i] || l !== elo[i]) begin
        miscompares++;
        $display("FAIL directed[%0d]: busy_cycles=%0d hi=%h lo=%h, expected %0d %h %h",
                 i, nb, h, l, EXP_BUSY, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_ignore_invalid();
    logic [3:0] bad[3] = '{4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      mul_control = bad[i];
      step();
      mul_control = 4'd0;
      step();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL invalid_op[%0d]: busy=%b, expected 0", i, busy);
      end
    end
  endtask

  task automatic test_idle_write_read();
    logic [W-1:0] old_hi, old_lo;
    old_hi = hi_out;
    old_lo = lo_out;
    hi_we = 1'b1; wdata = 32'hCAFE0001; hilo_rd = 1'b1;
    #1;
    vectors++;
    if (stall_req !== 1'b0 || hi_out !== old_hi) begin
      miscompares++;
      $display("FAIL idle_rd_wr: stall=%b hi=%h, expected 0 %h", stall_req, hi_out, old_hi);
    end
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0BADF00D;
    vectors++;
    if (hi_out !== 32'hCAFE0001 || lo_out !== old_lo) begin
      miscompares++;
      $display("FAIL mthi: hi=%h lo=%h, expected CAFE0001 %h", hi_out, lo_out, old_lo);
    end
    step();
    lo_we = 1'b0; hilo_rd = 1'b0;
    vectors++;
    if (lo_out !== 32'h0BADF00D || hi_out !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL mtlo: hi=%h lo=%h, expected CAFE0001 0BADF00D", hi_out, lo_out);
    end
  endtask

  task automatic test_busy_interactions();
    logic [W-1:0] old_hi, old_lo;
    int nb;
    old_hi = hi_out;
    old_lo = lo_out;
    mul_control = multu_mc; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    step();
    mul_control = 4'd0;
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      if (nb == 5) hilo_rd = 1'b1;
      if (nb == 6) begin hi_we = 1'b1; wdata = 32'h1234; end
      if (nb == 7) begin mul_control = mult_mc; src_a = 32'd5; src_b = 32'd5; end
      #1;
      if (nb >= 5 && nb <= 8) begin
        vectors++;
        if (stall_req !== (nb != 8) || hi_out !== old_hi || lo_out !== old_lo) begin
          miscompares++;
          $display("FAIL busy_stall cyc%0d: stall=%b hi=%h lo=%h, expected %b %h %h",
                   nb, stall_req, hi_out, lo_out, nb != 8, old_hi, old_lo);
        end
      end
      step();
      hilo_rd = 1'b0; hi_we = 1'b0; mul_control = 4'd0;
    end
    vectors++;
    if (nb !== EXP_BUSY || hi_out !== 32'hFFFFFFFE || lo_out !== 32'h1) begin
      miscompares++;
      $display("FAIL busy_result: busy_cycles=%0d hi=%h lo=%h, expected %0d FFFFFFFE 00000001",
               nb, hi_out, lo_out, EXP_BUSY);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    logic [W-1:0] h, l;
    mul_control = mult_mc; src_a = 32'h12345; src_b = 32'h6789;
    step();                       // now in PREP
    mul_control = 4'd0;
    repeat (11) step();           // now in CALC iteration 10
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi_out, lo_out);
    end
    do_op(divu_mc, 32'd9, 32'd2, nb, h, l);
    vectors++;
    if (nb !== EXP_BUSY || l !== 32'd4 || h !== 32'd1) begin
      miscompares++;
      $display("FAIL after_reset_divu: busy_cycles=%0d hi=%h lo=%h, expected %0d 1 4", nb, h, l, EXP_BUSY);
    end
  endtask

  task automatic test_same_cycle();
    int nb;
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    mul_control = multu_mc; src_a = 32'd2; src_b = 32'd3;
    step();
    hi_we = 1'b0; mul_control = 4'd0; src_a = $urandom; src_b = $urandom;
    vectors++;
    if (hi_out !== 32'hA5A5A5A5 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cycle_mthi: hi=%h busy=%b, expected A5A5A5A5 1", hi_out, busy);
    end
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin nb++; step(); end
    vectors++;
    if (nb !== EXP_BUSY || hi_out !== 32'd0 || lo_out !== 32'd6) begin
      miscompares++;
      $display("FAIL same_cycle_result: busy_cycles=%0d hi=%h lo=%h, expected %0d 0 6", nb, hi_out, lo_out, EXP_BUSY);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [W-1:0] a, b, h, l, eh, el;
    int nb, mode;
    for (int i = 0; i < 30; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      mode = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = '0;
      if (mode == 1) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      if (mode == 2) begin a = -$urandom_range(0, 50); b = $urandom_range(1, 9); end
      if (mode == 3) b = b >> $urandom_range(0, 28);
      ref_op(op, a, b, eh, el);
      do_op(op, a, b, nb, h, l);
      vectors++;
      if (nb !== EXP_BUSY || h !== eh || l !== el) begin
        miscompares++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: busy_cycles=%0d hi=%h lo=%h, expected %0d %h %h",
                 i, op, a, b, nb, h, l, EXP_BUSY, eh, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_invalid();
    test_idle_write_read();
    test_busy_interactions();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
